// File: rtl/ysyx_24100029_xbar.sv
// Single-master AXI4 crossbar: reads go to the CLINT or the SoC by address; writes
// go to the SoC only, and a write into the CLINT window gets a SLVERR response.
module ysyx_24100029_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    // upstream
    input  logic [31:0] in_araddr,
    input  logic [3:0]  in_arid,
    input  logic [7:0]  in_arlen,
    input  logic [2:0]  in_arsize,
    input  logic [1:0]  in_arburst,
    input  logic        in_arvalid,
    output logic        in_arready,
    output logic [31:0] in_rdata,
    output logic [1:0]  in_rresp,
    output logic [3:0]  in_rid,
    output logic        in_rlast,
    output logic        in_rvalid,
    input  logic        in_rready,
    input  logic [31:0] in_awaddr,
    input  logic [3:0]  in_awid,
    input  logic [7:0]  in_awlen,
    input  logic [2:0]  in_awsize,
    input  logic [1:0]  in_awburst,
    input  logic        in_awvalid,
    output logic        in_awready,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    input  logic        in_wlast,
    input  logic        in_wvalid,
    output logic        in_wready,
    output logic [1:0]  in_bresp,
    output logic [3:0]  in_bid,
    output logic        in_bvalid,
    input  logic        in_bready,
    // CLINT (read only)
    output logic [31:0] clint_araddr,
    output logic [3:0]  clint_arid,
    output logic [7:0]  clint_arlen,
    output logic [2:0]  clint_arsize,
    output logic [1:0]  clint_arburst,
    output logic        clint_arvalid,
    input  logic        clint_arready,
    input  logic [31:0] clint_rdata,
    input  logic [1:0]  clint_rresp,
    input  logic [3:0]  clint_rid,
    input  logic        clint_rlast,
    input  logic        clint_rvalid,
    output logic        clint_rready,
    // SoC
    output logic [31:0] soc_araddr,
    output logic [3:0]  soc_arid,
    output logic [7:0]  soc_arlen,
    output logic [2:0]  soc_arsize,
    output logic [1:0]  soc_arburst,
    output logic        soc_arvalid,
    input  logic        soc_arready,
    input  logic [31:0] soc_rdata,
    input  logic [1:0]  soc_rresp,
    input  logic [3:0]  soc_rid,
    input  logic        soc_rlast,
    input  logic        soc_rvalid,
    output logic        soc_rready,
    output logic [31:0] soc_awaddr,
    output logic [3:0]  soc_awid,
    output logic [7:0]  soc_awlen,
    output logic [2:0]  soc_awsize,
    output logic [1:0]  soc_awburst,
    output logic        soc_awvalid,
    input  logic        soc_awready,
    output logic [31:0] soc_wdata,
    output logic [3:0]  soc_wstrb,
    output logic        soc_wlast,
    output logic        soc_wvalid,
    input  logic        soc_wready,
    input  logic [1:0]  soc_bresp,
    input  logic [3:0]  soc_bid,
    input  logic        soc_bvalid,
    output logic        soc_bready
);

    typedef enum logic [1:0] {R_IDLE, R_CLINT, R_SOC} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SOC, W_ERR_DATA, W_ERR_RESP} wr_state_t;

    rd_state_t   r_rd_state, w_rd_next;
    wr_state_t   r_wr_state, w_wr_next;
    logic [3:0]  r_arid, r_awid;
    logic        w_arid_load, w_awid_load;
    logic        w_ar_hit, w_aw_hit, w_ar_sel_ready;
    logic        w_unused_clint;

    assign w_ar_hit       = (in_araddr & CLINT_MASK) == CLINT_BASE;
    assign w_aw_hit       = (in_awaddr & CLINT_MASK) == CLINT_BASE;
    assign w_ar_sel_ready = w_ar_hit ? clint_arready : soc_arready;
    // The CLINT drives neither rid nor rlast; they are regenerated locally.
    assign w_unused_clint = ^{clint_rid, clint_rlast};

    assign clint_araddr  = in_araddr;
    assign clint_arid    = in_arid;
    assign clint_arlen   = in_arlen;
    assign clint_arsize  = in_arsize;
    assign clint_arburst = in_arburst;
    assign soc_araddr    = in_araddr;
    assign soc_arid      = in_arid;
    assign soc_arlen     = in_arlen;
    assign soc_arsize    = in_arsize;
    assign soc_arburst   = in_arburst;
    assign soc_awaddr    = in_awaddr;
    assign soc_awid      = in_awid;
    assign soc_awlen     = in_awlen;
    assign soc_awsize    = in_awsize;
    assign soc_awburst   = in_awburst;
    assign soc_wdata     = in_wdata;
    assign soc_wstrb     = in_wstrb;
    assign soc_wlast     = in_wlast;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_arid     <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_arid_load) r_arid <= in_arid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_awid     <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_awid_load) r_awid <= in_awid;
        end
    end

    // Handshake outputs are gated by reset so nothing leaks while it is held.
    always_comb begin
        w_rd_next     = r_rd_state;
        w_arid_load   = 1'b0;
        in_arready    = 1'b0;
        clint_arvalid = 1'b0;
        soc_arvalid   = 1'b0;
        in_rdata      = '0;
        in_rresp      = '0;
        in_rid        = '0;
        in_rlast      = 1'b0;
        in_rvalid     = 1'b0;
        clint_rready  = 1'b0;
        soc_rready    = 1'b0;
        if (!reset) begin
            unique case (r_rd_state)
                R_IDLE: begin
                    clint_arvalid = in_arvalid & w_ar_hit;
                    soc_arvalid   = in_arvalid & ~w_ar_hit;
                    in_arready    = w_ar_sel_ready;
                    if (in_arvalid && w_ar_sel_ready) begin
                        w_arid_load = 1'b1;
                        w_rd_next   = w_ar_hit ? R_CLINT : R_SOC;
                    end
                end
                R_CLINT: begin
                    in_rdata     = clint_rdata;
                    in_rresp     = clint_rresp;
                    in_rid       = r_arid;
                    in_rlast     = 1'b1;
                    in_rvalid    = clint_rvalid;
                    clint_rready = in_rready;
                    if (clint_rvalid && in_rready) w_rd_next = R_IDLE;
                end
                R_SOC: begin
                    in_rdata   = soc_rdata;
                    in_rresp   = soc_rresp;
                    in_rid     = soc_rid;
                    in_rlast   = soc_rlast;
                    in_rvalid  = soc_rvalid;
                    soc_rready = in_rready;
                    if (soc_rvalid && in_rready && soc_rlast) w_rd_next = R_IDLE;
                end
                default: w_rd_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wr_next   = r_wr_state;
        w_awid_load = 1'b0;
        in_awready  = 1'b0;
        soc_awvalid = 1'b0;
        in_wready   = 1'b0;
        soc_wvalid  = 1'b0;
        in_bresp    = '0;
        in_bid      = '0;
        in_bvalid   = 1'b0;
        soc_bready  = 1'b0;
        if (!reset) begin
            unique case (r_wr_state)
                W_IDLE: begin
                    soc_awvalid = in_awvalid & ~w_aw_hit;
                    in_awready  = w_aw_hit ? 1'b1 : soc_awready;
                    if (in_awvalid && (w_aw_hit || soc_awready)) begin
                        w_awid_load = 1'b1;
                        w_wr_next   = w_aw_hit ? W_ERR_DATA : W_SOC;
                    end
                end
                W_SOC: begin
                    soc_wvalid = in_wvalid;
                    in_wready  = soc_wready;
                    in_bresp   = soc_bresp;
                    in_bid     = soc_bid;
                    in_bvalid  = soc_bvalid;
                    soc_bready = in_bready;
                    if (soc_bvalid && in_bready) w_wr_next = W_IDLE;
                end
                W_ERR_DATA: begin
                    in_wready = 1'b1;
                    if (in_wvalid && in_wlast) w_wr_next = W_ERR_RESP;
                end
                W_ERR_RESP: begin
                    in_bvalid = 1'b1;
                    in_bresp  = 2'b10;
                    in_bid    = r_awid;
                    if (in_bready) w_wr_next = W_IDLE;
                end
                default: w_wr_next = W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_xbar.sv
// Directed + randomized bench for ysyx_24100029_xbar; target slaves are driven
// from the stimulus sequence and expectations come from the address-routing rules.
module tb_ysyx_24100029_xbar;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clock, reset;
    logic [31:0] in_araddr;  logic [3:0] in_arid; logic [7:0] in_arlen; logic [2:0] in_arsize;
    logic [1:0]  in_arburst; logic in_arvalid, in_arready;
    logic [31:0] in_rdata;   logic [1:0] in_rresp; logic [3:0] in_rid; logic in_rlast, in_rvalid, in_rready;
    logic [31:0] in_awaddr;  logic [3:0] in_awid; logic [7:0] in_awlen; logic [2:0] in_awsize;
    logic [1:0]  in_awburst; logic in_awvalid, in_awready;
    logic [31:0] in_wdata;   logic [3:0] in_wstrb; logic in_wlast, in_wvalid, in_wready;
    logic [1:0]  in_bresp;   logic [3:0] in_bid; logic in_bvalid, in_bready;
    logic [31:0] clint_araddr; logic [3:0] clint_arid; logic [7:0] clint_arlen; logic [2:0] clint_arsize;
    logic [1:0]  clint_arburst; logic clint_arvalid, clint_arready;
    logic [31:0] clint_rdata; logic [1:0] clint_rresp; logic [3:0] clint_rid;
    logic        clint_rlast, clint_rvalid, clint_rready;
    logic [31:0] soc_araddr; logic [3:0] soc_arid; logic [7:0] soc_arlen; logic [2:0] soc_arsize;
    logic [1:0]  soc_arburst; logic soc_arvalid, soc_arready;
    logic [31:0] soc_rdata;  logic [1:0] soc_rresp; logic [3:0] soc_rid; logic soc_rlast, soc_rvalid, soc_rready;
    logic [31:0] soc_awaddr; logic [3:0] soc_awid; logic [7:0] soc_awlen; logic [2:0] soc_awsize;
    logic [1:0]  soc_awburst; logic soc_awvalid, soc_awready;
    logic [31:0] soc_wdata;  logic [3:0] soc_wstrb; logic soc_wlast, soc_wvalid, soc_wready;
    logic [1:0]  soc_bresp;  logic [3:0] soc_bid; logic soc_bvalid, soc_bready;

    int checks = 0;
    int errors = 0;

    ysyx_24100029_xbar #(.CLINT_BASE(BASE), .CLINT_MASK(MASK)) dut (
        .clock(clock), .reset(reset),
        .in_araddr(in_araddr), .in_arid(in_arid), .in_arlen(in_arlen), .in_arsize(in_arsize),
        .in_arburst(in_arburst), .in_arvalid(in_arvalid), .in_arready(in_arready),
        .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rid(in_rid), .in_rlast(in_rlast),
        .in_rvalid(in_rvalid), .in_rready(in_rready),
        .in_awaddr(in_awaddr), .in_awid(in_awid), .in_awlen(in_awlen), .in_awsize(in_awsize),
        .in_awburst(in_awburst), .in_awvalid(in_awvalid), .in_awready(in_awready),
        .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast), .in_wvalid(in_wvalid),
        .in_wready(in_wready), .in_bresp(in_bresp), .in_bid(in_bid), .in_bvalid(in_bvalid),
        .in_bready(in_bready),
        .clint_araddr(clint_araddr), .clint_arid(clint_arid), .clint_arlen(clint_arlen),
        .clint_arsize(clint_arsize), .clint_arburst(clint_arburst), .clint_arvalid(clint_arvalid),
        .clint_arready(clint_arready), .clint_rdata(clint_rdata), .clint_rresp(clint_rresp),
        .clint_rid(clint_rid), .clint_rlast(clint_rlast), .clint_rvalid(clint_rvalid),
        .clint_rready(clint_rready),
        .soc_araddr(soc_araddr), .soc_arid(soc_arid), .soc_arlen(soc_arlen), .soc_arsize(soc_arsize),
        .soc_arburst(soc_arburst), .soc_arvalid(soc_arvalid), .soc_arready(soc_arready),
        .soc_rdata(soc_rdata), .soc_rresp(soc_rresp), .soc_rid(soc_rid), .soc_rlast(soc_rlast),
        .soc_rvalid(soc_rvalid), .soc_rready(soc_rready),
        .soc_awaddr(soc_awaddr), .soc_awid(soc_awid), .soc_awlen(soc_awlen), .soc_awsize(soc_awsize),
        .soc_awburst(soc_awburst), .soc_awvalid(soc_awvalid), .soc_awready(soc_awready),
        .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb), .soc_wlast(soc_wlast), .soc_wvalid(soc_wvalid),
        .soc_wready(soc_wready), .soc_bresp(soc_bresp), .soc_bid(soc_bid), .soc_bvalid(soc_bvalid),
        .soc_bready(soc_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit is_clint(input logic [31:0] a);
        return (a & MASK) == BASE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_araddr = '0; in_arid = '0; in_arlen = '0; in_arsize = 3'd2; in_arburst = 2'b01;
        in_arvalid = 0; in_rready = 0;
        in_awaddr = '0; in_awid = '0; in_awlen = '0; in_awsize = 3'd2; in_awburst = 2'b01;
        in_awvalid = 0; in_wdata = '0; in_wstrb = '0; in_wlast = 0; in_wvalid = 0; in_bready = 0;
        clint_arready = 0; clint_rdata = '0; clint_rresp = '0; clint_rid = '0; clint_rlast = 0; clint_rvalid = 0;
        soc_arready = 0; soc_rdata = '0; soc_rresp = '0; soc_rid = '0; soc_rlast = 0; soc_rvalid = 0;
        soc_awready = 0; soc_wready = 0; soc_bresp = '0; soc_bid = '0; soc_bvalid = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arready"}, in_arready, 0);   chk({tag, "_rvalid"}, in_rvalid, 0);
        chk({tag, "_awready"}, in_awready, 0);   chk({tag, "_wready"}, in_wready, 0);
        chk({tag, "_bvalid"}, in_bvalid, 0);     chk({tag, "_rresp"}, in_rresp, 0);
        chk({tag, "_rid"}, in_rid, 0);           chk({tag, "_bresp"}, in_bresp, 0);
        chk({tag, "_bid"}, in_bid, 0);           chk({tag, "_c_arvalid"}, clint_arvalid, 0);
        chk({tag, "_c_rready"}, clint_rready, 0); chk({tag, "_s_arvalid"}, soc_arvalid, 0);
        chk({tag, "_s_rready"}, soc_rready, 0);  chk({tag, "_s_awvalid"}, soc_awvalid, 0);
        chk({tag, "_s_wvalid"}, soc_wvalid, 0);  chk({tag, "_s_bready"}, soc_bready, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int unsigned beats);
        bit hit = is_clint(addr);
        int unsigned n = hit ? 1 : beats;
        logic [31:0] d; logic [1:0] rs; logic [3:0] sid;
        in_araddr = addr; in_arid = id; in_arvalid = 1; in_rready = 0;
        clint_arready = !hit; soc_arready = hit;
        #1;
        chk("rd_clint_arvalid", clint_arvalid, hit);
        chk("rd_soc_arvalid", soc_arvalid, !hit);
        chk("rd_arready_unsel", in_arready, 0);
        clint_arready = 1; soc_arready = 1;
        #1;
        chk("rd_arready_sel", in_arready, 1);
        tick();
        in_araddr = $urandom; in_arid = 4'($urandom);
        #1;
        chk("rd_block_arready", in_arready, 0);
        chk("rd_block_c_arvalid", clint_arvalid, 0);
        chk("rd_block_s_arvalid", soc_arvalid, 0);
        for (int unsigned i = 0; i < n; i++) begin
            d = $urandom; rs = 2'($urandom); sid = 4'($urandom);
            if (hit) begin
                clint_rvalid = 1; clint_rdata = d; clint_rresp = rs; clint_rid = sid; clint_rlast = 0;
            end else begin
                soc_rvalid = 1; soc_rdata = d; soc_rresp = rs; soc_rid = sid; soc_rlast = (i == n - 1);
            end
            in_rready = 0;
            #1;
            chk("rd_rvalid", in_rvalid, 1);
            chk("rd_rdata", in_rdata, d);
            chk("rd_rresp", in_rresp, rs);
            chk("rd_rid", in_rid, hit ? id : sid);
            chk("rd_rlast", in_rlast, hit ? 1 : (i == n - 1));
            chk("rd_c_rready_lo", clint_rready, 0);
            chk("rd_s_rready_lo", soc_rready, 0);
            chk("rd_pend_arready", in_arready, 0);
            in_rready = 1;
            #1;
            chk("rd_c_rready", clint_rready, hit);
            chk("rd_s_rready", soc_rready, !hit);
            if (i == n - 1) in_arvalid = 0;
            tick();
        end
        #1;
        chk("rd_back_idle", in_rvalid, 0);
        clear_in();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int unsigned beats);
        bit hit = is_clint(addr);
        logic [31:0] d; logic [3:0] st; logic [1:0] rs; logic [3:0] sid;
        in_awaddr = addr; in_awid = id; in_awvalid = 1;
        in_wvalid = 1; in_wdata = $urandom; in_wlast = 1;
        soc_awready = 0; soc_wready = 1;
        #1;
        chk("wr_soc_awvalid", soc_awvalid, !hit);
        chk("wr_awready", in_awready, hit);
        chk("wr_idle_wready", in_wready, 0);
        chk("wr_idle_s_wvalid", soc_wvalid, 0);
        soc_awready = 1;
        #1;
        chk("wr_awready_rdy", in_awready, 1);
        tick();
        in_awvalid = 0;
        for (int unsigned i = 0; i < beats; i++) begin
            d = $urandom; st = 4'($urandom);
            in_wdata = d; in_wstrb = st; in_wlast = (i == beats - 1); in_wvalid = 1;
            #1;
            chk("wr_wready", in_wready, 1);
            chk("wr_s_wvalid", soc_wvalid, !hit);
            chk("wr_s_wdata", soc_wdata, d);
            chk("wr_s_wstrb", soc_wstrb, st);
            chk("wr_bvalid_early", in_bvalid, 0);
            tick();
        end
        in_wvalid = 0; in_wlast = 0;
        rs = 2'($urandom); sid = 4'($urandom);
        if (!hit) begin soc_bvalid = 1; soc_bresp = rs; soc_bid = sid; end
        in_bready = 0;
        #1;
        chk("wr_bvalid", in_bvalid, 1);
        chk("wr_bresp", in_bresp, hit ? 2'b10 : rs);
        chk("wr_bid", in_bid, hit ? id : sid);
        chk("wr_s_bready_lo", soc_bready, 0);
        tick();
        chk("wr_bvalid_hold", in_bvalid, 1);
        in_bready = 1;
        #1;
        chk("wr_s_bready", soc_bready, !hit);
        tick();
        chk("wr_back_idle", in_bvalid, 0);
        clear_in();
    endtask

    initial begin
        logic [31:0] d, d2, a;
        clear_in();
        reset = 1;
        in_arvalid = 1; in_awvalid = 1; in_wvalid = 1; in_rready = 1; in_bready = 1;
        soc_rvalid = 1; soc_rid = 4'hF; soc_rresp = 2'b11; soc_bvalid = 1; soc_bresp = 2'b11; soc_bid = 4'hF;
        clint_arready = 1; soc_arready = 1; soc_awready = 1; soc_wready = 1;
        #12;
        chk_quiet("rst");
        clear_in();
        tick();
        reset = 0;
        #1;
        chk_quiet("idle");

        // directed cases from the address map
        do_read(32'h0200_0000, 4'd3, 1);
        do_read(32'h8000_0000, 4'd5, 1);
        do_write(32'h0200_0004, 4'd2, 1);
        do_write(32'h8000_1000, 4'd7, 2);
        do_read(32'h0200_FFFC, 4'd1, 1);
        do_read(32'h0201_0000, 4'd4, 2);

        // concurrent CLINT read and SoC write
        d = $urandom; d2 = $urandom;
        in_araddr = 32'h0200_0004; in_arid = 4'd6; in_arvalid = 1; clint_arready = 1;
        in_awaddr = 32'hA000_0000; in_awid = 4'd9; in_awvalid = 1; soc_awready = 1;
        #1;
        chk("par_arready", in_arready, 1);
        chk("par_awready", in_awready, 1);
        chk("par_c_arvalid", clint_arvalid, 1);
        chk("par_s_arvalid", soc_arvalid, 0);
        chk("par_s_awvalid", soc_awvalid, 1);
        tick();
        in_arvalid = 0; in_awvalid = 0;
        clint_rvalid = 1; clint_rdata = d; in_rready = 1;
        in_wvalid = 1; in_wdata = d2; in_wlast = 1; soc_wready = 1;
        #1;
        chk("par_rvalid", in_rvalid, 1);
        chk("par_rdata", in_rdata, d);
        chk("par_rid", in_rid, 6);
        chk("par_rlast", in_rlast, 1);
        chk("par_s_wvalid", soc_wvalid, 1);
        chk("par_s_wdata", soc_wdata, d2);
        chk("par_wready", in_wready, 1);
        tick();
        clint_rvalid = 0; in_wvalid = 0; in_wlast = 0;
        soc_bvalid = 1; soc_bid = 4'd9; soc_bresp = 2'b00; in_bready = 1;
        #1;
        chk("par_bvalid", in_bvalid, 1);
        chk("par_bid", in_bid, 9);
        chk("par_r_done", in_rvalid, 0);
        tick();
        chk("par_w_done", in_bvalid, 0);
        clear_in();

        // randomized traffic
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = BASE | (a & ~MASK);
            if ($urandom_range(0, 1) == 1)
                do_read(a, 4'($urandom), $urandom_range(1, 3));
            else
                do_write(a, 4'($urandom), $urandom_range(1, 3));
        end

        // reset while a SoC read is outstanding
        in_araddr = 32'h8000_0040; in_arid = 4'd8; in_arvalid = 1; soc_arready = 1;
        tick();
        in_arvalid = 0; in_rready = 1;
        #1;
        reset = 1;
        #1;
        chk_quiet("rst_fly");
        tick();
        reset = 0;
        soc_rvalid = 1; soc_rlast = 1; soc_rid = 4'd8; soc_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_no_stale_rvalid", in_rvalid, 0);
        chk("rst_no_stale_rready", soc_rready, 0);
        tick();
        chk("rst_no_stale_rvalid2", in_rvalid, 0);
        clear_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24100029_xbar.md
YSYX_24100029_XBAR -- requirements
Module: ysyx_24100029_xbar

Interface
REQ-001 Parameter CLINT_BASE, default 32'h0200_0000, base address of the CLINT window.
REQ-002 Parameter CLINT_MASK, default 32'hFFFF_0000, address bits compared against CLINT_BASE.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_araddr/in_arid/in_arlen/in_arsize/in_arburst  input  32/4/8/3/2  upstream read-address payload.
REQ-006 in_arvalid  input  1, and in_arready  output  1: upstream AR handshake.
REQ-007 in_rdata/in_rresp/in_rid/in_rlast/in_rvalid  output  32/2/4/1/1, and in_rready  input  1: upstream R channel.
REQ-008 in_awaddr/in_awid/in_awlen/in_awsize/in_awburst/in_awvalid  input  32/4/8/3/2/1, and in_awready  output  1: upstream AW channel.
REQ-009 in_wdata/in_wstrb/in_wlast/in_wvalid  input  32/4/1/1, and in_wready  output  1: upstream W channel.
REQ-010 in_bresp/in_bid/in_bvalid  output  2/4/1, and in_bready  input  1: upstream B channel.
REQ-011 clint_ar*/clint_r*  mirror of REQ-005..007 with direction reversed: read-only port to the CLINT.
REQ-012 soc_ar*/soc_r*/soc_aw*/soc_w*/soc_b*  mirror of REQ-005..010 with direction reversed: full AXI4 port to the SoC.

Function
REQ-013 Address decode: CLINT hit when (addr & CLINT_MASK) == CLINT_BASE; every other address routes to SoC.
REQ-014 Read FSM states: R_IDLE, R_CLINT, R_SOC; write FSM states: W_IDLE, W_SOC, W_ERR_DATA, W_ERR_RESP; the two FSMs run independently.
REQ-015 In R_IDLE, in_ar* is forwarded combinationally to the decoded target only; the non-selected target's arvalid is 0, and in_arready equals the selected target's arready.
REQ-016 On the AR handshake, in_arid is latched and the FSM moves to R_CLINT or R_SOC; in_arready is 0 and both target arvalid outputs are 0 until the FSM returns to R_IDLE.
REQ-017 In R_CLINT/R_SOC, the target's R channel is muxed to in_r*, in_rready goes to the selected target only, and the other target's rready is 0.
REQ-018 In R_CLINT, in_rlast is forced to 1 and in_rid to the latched arid, because the CLINT does not drive rlast/rid.
REQ-019 The read FSM returns to R_IDLE on the cycle in_rvalid & in_rready & in_rlast holds, so at most one read is outstanding.
REQ-020 In W_IDLE, an AW hitting SoC is forwarded combinationally (in_awready = soc_awready); on the handshake the FSM enters W_SOC.
REQ-021 In W_SOC, in_w* passes to soc_w* and soc_b* passes to in_b*; the FSM returns to W_IDLE on in_bvalid & in_bready.
REQ-022 An AW hitting CLINT is never forwarded: in_awready = 1 in W_IDLE, awid is latched, and the FSM enters W_ERR_DATA.
REQ-023 In W_ERR_DATA, in_wready = 1 and beats are discarded; the FSM moves to W_ERR_RESP on the beat with in_wvalid & in_wlast.
REQ-024 In W_ERR_RESP, in_bvalid = 1, in_bresp = 2'b10 (SLVERR) and in_bid = latched awid; the FSM returns to W_IDLE on in_bready.
REQ-025 in_wready and soc_wvalid are 0 in W_IDLE: W data is accepted only after its AW has been accepted.
REQ-026 AR and AW arriving in the same cycle are each accepted by their own FSM with no arbitration.
REQ-027 Added latency is zero cycles; every path is combinational except state and latched IDs.

Reset
REQ-028 While reset is high, both FSMs are forced to IDLE and the latched IDs to 0, regardless of clock.
REQ-029 During reset, all upstream ready/valid outputs and all target valid/ready outputs are 0; in_bresp, in_rresp, in_rid and in_bid are 0.
REQ-030 A transaction in flight when reset asserts is dropped; no response is produced for it after reset releases.

Verification
REQ-031 Read 0x0200_0000 with arid=3; CLINT returns 0x1234 -> in_rdata=0x1234, in_rid=3, in_rlast=1, in_rresp=0, and soc_arvalid stays 0.
REQ-032 Read 0x8000_0000 with arid=5 -> soc_arvalid=1 and clint_arvalid=0; the SoC R beat (rid=5, rlast=1) is passed through unchanged.
REQ-033 Write 0x0200_0004 with awid=2 and 1 beat -> no soc_awvalid, in_bresp=2'b10, in_bid=2, and in_bvalid is held until bready.
REQ-034 Second AR issued while the first read is pending -> in_arready=0 until the first in_rlast handshake completes.
REQ-035 Simultaneous read of 0x0200_0004 and write to 0xA000_0000 -> both proceed in parallel and each completes with the correct routing.
REQ-036 Assert reset while in R_SOC with rvalid low -> all outputs are 0 and no stale response appears after release.
